// File: rtl/sc_collision_scanner_pkg.sv
// Shared definitions for the SC_ collision-scanner blocks.
// Holds the scanner FSM state encoding and the width helpers used to size
// row-address and hit-count buses from the ROWS parameter.
package sc_collision_scanner_pkg;

  // Scanner control states.
  typedef enum logic [1:0] {
    SC_IDLE = 2'd0,
    SC_SCAN = 2'd1,
    SC_DONE = 2'd2
  } scState_t;

  // Bits needed to index rows 0..rows-1 (at least one bit).
  function automatic int addrWidth(input int rows);
    return (rows <= 2) ? 1 : $clog2(rows);
  endfunction

  // Bits needed to hold a count 0..rows.
  function automatic int countWidth(input int rows);
    return $clog2(rows + 1);
  endfunction

endpackage

// File: rtl/sc_row_overlap.sv
// Row overlap test: high when any bit of the player row and obstacle row are
// both set.
// Ports: player/obstacle row masks in, overlap out. Purely combinational.
module sc_row_overlap #(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] player,
  input  logic [DATAWIDTH-1:0] obstacle,
  output logic                 overlap
);

  assign overlap = |(player & obstacle);

endmodule

// File: rtl/sc_collision_scanner.sv
// Frame collision scanner: on start, walks rowAddr 0..ROWS-1 one row per
// cycle, counts rows where player and obstacle overlap, remembers the first
// such row, and on completion publishes the results and a sticky active-low
// collision flag (set when the count reaches HIT_THRESHOLD).
// Ports: CLOCK_50 / RESET_InHigh (sync), start/clear requests, per-row
// player/obstacle masks (combinational row source addressed by rowAddr);
// outputs rowAddr, busy, done pulse, collision (active low), hitCount, firstHit.
// All outputs come straight from registers.
module sc_collision_scanner
  import sc_collision_scanner_pkg::*;
#(
  parameter int DATAWIDTH     = 8,
  parameter int ROWS          = 16,
  parameter int HIT_THRESHOLD = 1
) (
  input  logic                          SC_CollisionScanner_CLOCK_50,
  input  logic                          SC_CollisionScanner_RESET_InHigh,
  input  logic                          SC_CollisionScanner_start_InHigh,
  input  logic                          SC_CollisionScanner_clear_InHigh,
  input  logic [DATAWIDTH-1:0]          SC_CollisionScanner_player_InBUS,
  input  logic [DATAWIDTH-1:0]          SC_CollisionScanner_obstacle_InBUS,
  output logic [addrWidth(ROWS)-1:0]    SC_CollisionScanner_rowAddr_OutBUS,
  output logic                          SC_CollisionScanner_busy_OutHigh,
  output logic                          SC_CollisionScanner_done_OutHigh,
  output logic                          SC_CollisionScanner_collision_OutLow,
  output logic [countWidth(ROWS)-1:0]   SC_CollisionScanner_hitCount_OutBUS,
  output logic [addrWidth(ROWS)-1:0]    SC_CollisionScanner_firstHit_OutBUS
);

  localparam int AW = addrWidth(ROWS);
  localparam int CW = countWidth(ROWS);

  scState_t         state;
  scState_t         stateNext;

  logic [AW-1:0]    rowAddr;
  logic             busy;
  logic             done;
  logic             collisionN;
  logic [CW-1:0]    hitCount;
  logic [AW-1:0]    firstHit;

  // Working registers for the scan in progress.
  logic [CW-1:0]    hitWork;
  logic [AW-1:0]    firstWork;
  logic             firstValid;

  logic             rowOverlap;
  logic             lastRow;
  logic             commitHit;

  sc_row_overlap #(
    .DATAWIDTH (DATAWIDTH)
  ) uRowOverlap (
    .player   (SC_CollisionScanner_player_InBUS),
    .obstacle (SC_CollisionScanner_obstacle_InBUS),
    .overlap  (rowOverlap)
  );

  assign lastRow   = (rowAddr == AW'(ROWS - 1));
  // The DONE cycle is where results are committed; a collision decided here
  // takes priority over a clear arriving in the same cycle.
  assign commitHit = (state == SC_DONE) && (hitWork >= CW'(HIT_THRESHOLD));

  // State register.
  always_ff @(posedge SC_CollisionScanner_CLOCK_50) begin
    if (SC_CollisionScanner_RESET_InHigh) begin
      state <= SC_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic. start outside IDLE is simply not looked at.
  always_comb begin
    stateNext = state;
    case (state)
      SC_IDLE: if (SC_CollisionScanner_start_InHigh) stateNext = SC_SCAN;
      SC_SCAN: if (lastRow) stateNext = SC_DONE;
      SC_DONE: stateNext = SC_IDLE;
      default: stateNext = SC_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge SC_CollisionScanner_CLOCK_50) begin
    if (SC_CollisionScanner_RESET_InHigh) begin
      rowAddr    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      collisionN <= 1'b1;
      hitCount   <= '0;
      firstHit   <= '0;
      hitWork    <= '0;
      firstWork  <= '0;
      firstValid <= 1'b0;
    end else begin
      // busy/done are registered copies of the state being entered, so they
      // line up with the state the FSM is actually in.
      busy <= (stateNext != SC_IDLE);
      done <= (stateNext == SC_DONE);

      case (state)
        SC_IDLE: begin
          rowAddr <= '0;
          if (SC_CollisionScanner_start_InHigh) begin
            hitWork    <= '0;
            firstWork  <= '0;
            firstValid <= 1'b0;
          end
        end
        SC_SCAN: begin
          // Hold at the last row; the address returns to 0 via DONE->IDLE.
          if (!lastRow) begin
            rowAddr <= rowAddr + AW'(1);
          end
          if (rowOverlap) begin
            if (hitWork != CW'(ROWS)) begin
              hitWork <= hitWork + CW'(1);
            end
            if (!firstValid) begin
              firstWork  <= rowAddr;
              firstValid <= 1'b1;
            end
          end
        end
        SC_DONE: begin
          rowAddr  <= '0;
          hitCount <= hitWork;
          firstHit <= firstValid ? firstWork : '0;
        end
        default: begin
          rowAddr <= '0;
        end
      endcase

      if (commitHit) begin
        collisionN <= 1'b0;
      end else if (SC_CollisionScanner_clear_InHigh) begin
        collisionN <= 1'b1;
      end
    end
  end

  assign SC_CollisionScanner_rowAddr_OutBUS   = rowAddr;
  assign SC_CollisionScanner_busy_OutHigh     = busy;
  assign SC_CollisionScanner_done_OutHigh     = done;
  assign SC_CollisionScanner_collision_OutLow = collisionN;
  assign SC_CollisionScanner_hitCount_OutBUS  = hitCount;
  assign SC_CollisionScanner_firstHit_OutBUS  = firstHit;

endmodule

// File: tb/tb_sc_collision_scanner.sv
// Directed bench for sc_collision_scanner: a default instance (threshold 1)
// and a threshold-3 instance share start/clear/reset; each reads the same row
// tables through its own rowAddr.
module tb_sc_collision_scanner;

  logic       clk;
  logic       rst;
  logic       start;
  logic       clear;

  logic [7:0] pMem [16];
  logic [7:0] oMem [16];

  logic [7:0] playerA, obstacleA, playerB, obstacleB;
  logic [3:0] addrA, addrB, firstA, firstB;
  logic [4:0] hitA, hitB;
  logic       busyA, busyB, doneA, doneB, colA, colB;

  int checks;
  int failures;

  sc_collision_scanner uDutA (
    .SC_CollisionScanner_CLOCK_50         (clk),
    .SC_CollisionScanner_RESET_InHigh     (rst),
    .SC_CollisionScanner_start_InHigh     (start),
    .SC_CollisionScanner_clear_InHigh     (clear),
    .SC_CollisionScanner_player_InBUS     (playerA),
    .SC_CollisionScanner_obstacle_InBUS   (obstacleA),
    .SC_CollisionScanner_rowAddr_OutBUS   (addrA),
    .SC_CollisionScanner_busy_OutHigh     (busyA),
    .SC_CollisionScanner_done_OutHigh     (doneA),
    .SC_CollisionScanner_collision_OutLow (colA),
    .SC_CollisionScanner_hitCount_OutBUS  (hitA),
    .SC_CollisionScanner_firstHit_OutBUS  (firstA)
  );

  sc_collision_scanner #(.HIT_THRESHOLD(3)) uDutB (
    .SC_CollisionScanner_CLOCK_50         (clk),
    .SC_CollisionScanner_RESET_InHigh     (rst),
    .SC_CollisionScanner_start_InHigh     (start),
    .SC_CollisionScanner_clear_InHigh     (clear),
    .SC_CollisionScanner_player_InBUS     (playerB),
    .SC_CollisionScanner_obstacle_InBUS   (obstacleB),
    .SC_CollisionScanner_rowAddr_OutBUS   (addrB),
    .SC_CollisionScanner_busy_OutHigh     (busyB),
    .SC_CollisionScanner_done_OutHigh     (doneB),
    .SC_CollisionScanner_collision_OutLow (colB),
    .SC_CollisionScanner_hitCount_OutBUS  (hitB),
    .SC_CollisionScanner_firstHit_OutBUS  (firstB)
  );

  // Combinational row source, as a frame buffer would present it.
  always_comb begin
    playerA   = pMem[addrA];
    obstacleA = oMem[addrA];
    playerB   = pMem[addrB];
    obstacleB = oMem[addrB];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Rows whose bit is set in mask get (pHit, oHit), all others (pNo, oNo).
  task automatic setRows(input logic [15:0] mask, input logic [7:0] pHit,
                         input logic [7:0] oHit, input logic [7:0] pNo,
                         input logic [7:0] oNo);
    for (int r = 0; r < 16; r++) begin
      pMem[r] = mask[r] ? pHit : pNo;
      oMem[r] = mask[r] ? oHit : oNo;
    end
  endtask

  // Pulses start, optionally re-pulses it after edge repeatAt (0 = never),
  // and waits for done. lat counts edges from the one sampling start to the
  // one after which done is seen. On return we sit at the negedge just after
  // the DONE cycle, with results committed.
  task automatic runScan(input int repeatAt, input logic clearAtDone,
                         output int lat, output logic busyAtDone);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    while (!doneA && lat < 40) begin
      start = (lat == repeatAt);
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = 1'b0;
    end
    busyAtDone = busyA;
    clear = clearAtDone;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
  endtask

  int   lat;
  logic busyAtDone;
  int   doneSeen;
  int   waitCnt;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    clear    = 1'b0;
    setRows(16'h0000, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset values.
    checkVal("rst_rowAddr", addrA, 0);
    checkVal("rst_busy", busyA, 0);
    checkVal("rst_done", doneA, 0);
    checkVal("rst_colN", colA, 1);
    checkVal("rst_hitCount", hitA, 0);
    checkVal("rst_firstHit", firstA, 0);
    rst = 1'b0;

    // Overlap on rows 3 and 9.
    setRows(16'h0208, 8'h18, 8'h10, 8'h18, 8'h00);
    runScan(0, 1'b0, lat, busyAtDone);
    checkVal("basic_latency", lat, 17);
    checkVal("basic_busyInDone", busyAtDone, 1);
    checkVal("basic_donePulseEnds", doneA, 0);
    checkVal("basic_busyAfter", busyA, 0);
    checkVal("basic_hitCount", hitA, 2);
    checkVal("basic_firstHit", firstA, 3);
    checkVal("basic_colN", colA, 0);
    checkVal("thr3_basic_hitCount", hitB, 2);
    checkVal("thr3_basic_colN", colB, 1);

    // Clear while idle.
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    checkVal("idleClear_colN", colA, 1);

    // No overlap anywhere.
    setRows(16'h0000, 8'h00, 8'h00, 8'hF0, 8'h0F);
    runScan(0, 1'b0, lat, busyAtDone);
    checkVal("none_hitCount", hitA, 0);
    checkVal("none_firstHit", firstA, 0);
    checkVal("none_colN", colA, 1);

    // Threshold 3: two overlapping rows are not enough, three are.
    setRows(16'h8001, 8'h18, 8'h10, 8'h18, 8'h00);
    runScan(0, 1'b0, lat, busyAtDone);
    checkVal("thr3_two_hitCount", hitB, 2);
    checkVal("thr3_two_colN", colB, 1);
    checkVal("thr3_two_firstHit", firstB, 0);
    checkVal("thr1_two_colN", colA, 0);
    setRows(16'h8081, 8'h18, 8'h10, 8'h18, 8'h00);
    runScan(0, 1'b0, lat, busyAtDone);
    checkVal("thr3_three_hitCount", hitB, 3);
    checkVal("thr3_three_colN", colB, 0);

    // Reset in the middle of a scan at rowAddr 5.
    setRows(16'h0208, 8'h18, 8'h10, 8'h18, 8'h00);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    waitCnt = 0;
    while (addrA != 4'd5 && waitCnt < 30) begin
      @(posedge clk);
      @(negedge clk);
      waitCnt++;
    end
    checkVal("midRst_reachedRow5", addrA, 5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkVal("midRst_rowAddr", addrA, 0);
    checkVal("midRst_busy", busyA, 0);
    checkVal("midRst_done", doneA, 0);
    checkVal("midRst_colN", colA, 1);
    checkVal("midRst_thr3_colN", colB, 1);
    checkVal("midRst_hitCount", hitB, 0);
    doneSeen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (doneA || busyA) doneSeen++;
    end
    checkVal("midRst_noDoneAfter", doneSeen, 0);

    // Start repeated at rowAddr 4 is ignored; clear coincides with DONE.
    runScan(5, 1'b1, lat, busyAtDone);
    checkVal("restart_latency", lat, 17);
    checkVal("restart_hitCount", hitA, 2);
    checkVal("clearAtDone_colN", colA, 0);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    checkVal("clearAfterDone_colN", colA, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
